// File: rtl/sc_add_seq_ctrl.sv
// Digit-serial WIDTH-bit adder controller driving one external 2-bit ripple slice, LS digit first.
// Optional subtract mode is enabled by defining SC_ADD_SUB_EN (adds the `sub` input).
module sc_add_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SC_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             slice_a1,
  output logic             slice_a0,
  output logic             slice_b1,
  output logic             slice_b0,
  output logic             slice_ci,
  input  logic             slice_co,
  input  logic             slice_s1,
  input  logic             slice_s0
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
    $error("sc_add_seq_ctrl: WIDTH must be even and >= 2");
  end

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             run;

  // Subtraction is A + ~B + 1, so only the B operand and carry-in differ at load time.
  always_comb begin
    b_load = op_b;
    c_load = cin;
`ifdef SC_ADD_SUB_EN
    if (sub) begin
      b_load = ~op_b;
      c_load = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = b_load;
          carry_d = c_load;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = (res_q >> 2) | (WIDTH'({slice_s1, slice_s0}) << (WIDTH - 2));
        a_d     = a_q >> 2;
        b_d     = b_q >> 2;
        carry_d = slice_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = res_d;
          cout_d  = slice_co;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  // Slice inputs are gated so they read zero whenever the controller is idle.
  assign run      = (state_q == RUN);
  assign busy     = run;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign slice_a1 = run & a_q[1];
  assign slice_a0 = run & a_q[0];
  assign slice_b1 = run & b_q[1];
  assign slice_b0 = run & b_q[0];
  assign slice_ci = run & carry_q;

endmodule

// File: tb/tb_sc_add_seq_ctrl.sv
// Directed bench for sc_add_seq_ctrl with a behavioural 2-bit slice; covers SC_ADD_SUB_EN when defined.
module tb_sc_add_seq_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;
  logic             slice_a1, slice_a0, slice_b1, slice_b0, slice_ci;
  logic             slice_co, slice_s1, slice_s0;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // External ripple slice model: {co, s1, s0} = a + b + ci.
  assign {slice_co, slice_s1, slice_s0} = {1'b0, slice_a1, slice_a0}
                                        + {1'b0, slice_b1, slice_b0}
                                        + {2'b00, slice_ci};

  sc_add_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
`ifdef SC_ADD_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .slice_a1 (slice_a1),
    .slice_a0 (slice_a0),
    .slice_b1 (slice_b1),
    .slice_b0 (slice_b0),
    .slice_ci (slice_ci),
    .slice_co (slice_co),
    .slice_s1 (slice_s1),
    .slice_s0 (slice_s0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_slice(input string tag);
    chk(tag, {27'd0, slice_a1, slice_a0, slice_b1, slice_b0, slice_ci}, 32'd0);
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    op_a  = a;
    op_b  = b;
    cin   = c;
    sub   = s;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Positioned in RUN cycle 1; ea/eb are the operand values the slice should see digit by digit.
  task automatic check_run(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic [3:0] eci, input logic [7:0] esum, input logic ecout);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_done_run"}, {31'd0, done}, 32'd0);
      chk({tag, "_slice_a"}, {30'd0, slice_a1, slice_a0}, {30'd0, ea[2*k+1], ea[2*k]});
      chk({tag, "_slice_b"}, {30'd0, slice_b1, slice_b0}, {30'd0, eb[2*k+1], eb[2*k]});
      chk({tag, "_slice_ci"}, {31'd0, slice_ci}, {31'd0, eci[k]});
      step();
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, esum});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
    chk_idle_slice({tag, "_slice_idle"});
  endtask

  initial begin
    // Reset held two cycles with start and operands active.
    rst   = 1'b1;
    start = 1'b1;
    op_a  = 8'hA5;
    op_b  = 8'h3C;
    cin   = 1'b1;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk_idle_slice("rst_slice");
    rst   = 1'b0;
    start = 1'b0;
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 0xA5 + 0x3C = 0xE1, carries into digits 2 and 3.
    launch(8'hA5, 8'h3C, 1'b0, 1'b0);
    check_run("a5_3c", 8'hA5, 8'h3C, 4'b1100, 8'hE1, 1'b0);
    step();
    chk("a5_3c_done_drop", {31'd0, done}, 32'd0);
    chk("a5_3c_sum_hold", {24'd0, sum}, 32'h0000_00E1);

    // Full carry ripple then all-zero.
    launch(8'hFF, 8'h00, 1'b1, 1'b0);
    check_run("ripple", 8'hFF, 8'h00, 4'b1111, 8'h00, 1'b1);
    step();
    launch(8'h00, 8'h00, 1'b0, 1'b0);
    check_run("zero", 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0);
    step();

    // start held through RUN: ignored until the done cycle, where it is accepted.
    op_a  = 8'h80;
    op_b  = 8'h80;
    cin   = 1'b0;
    start = 1'b1;
    step();
    op_a = 8'h11;
    op_b = 8'h22;
    check_run("b2b_first", 8'h80, 8'h80, 4'b0000, 8'h00, 1'b1);
    step();
    start = 1'b0;
    chk("b2b_single_done", {31'd0, done}, 32'd0);
    check_run("b2b_second", 8'h11, 8'h22, 4'b0000, 8'h33, 1'b0);
    step();
    chk("b2b_second_drop", {31'd0, done}, 32'd0);

    // Reset asserted in the 2nd RUN cycle aborts the operation.
    launch(8'h55, 8'h55, 1'b0, 1'b0);
    step();
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    chk_idle_slice("abort_slice");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    launch(8'h55, 8'h55, 1'b0, 1'b0);
    check_run("after_abort", 8'h55, 8'h55, 4'b0000, 8'hAA, 1'b0);
    step();

`ifdef SC_ADD_SUB_EN
    // 0x10 - 0x01: slice sees ~0x01 = 0xFE with carry-in 1.
    launch(8'h10, 8'h01, 1'b0, 1'b1);
    check_run("sub_10_01", 8'h10, 8'hFE, 4'b1001, 8'h0F, 1'b1);
    step();
    // 0x01 - 0x02 borrows: cin input is ignored in subtract mode.
    launch(8'h01, 8'h02, 1'b0, 1'b1);
    check_run("sub_01_02", 8'h01, 8'hFD, 4'b0001, 8'hFF, 1'b0);
    step();
    launch(8'h01, 8'h02, 1'b0, 1'b0);
    check_run("add_01_02", 8'h01, 8'h02, 4'b0000, 8'h03, 1'b0);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
